// File: rtl/decode_logic_pkg.sv
// Shared constants for the 6502-subset core: control-enable bit positions,
// supported opcodes and small decode helpers used by datapath and decoder.
package decode_logic_pkg;

    localparam int unsigned EN_W = 64;
    localparam int unsigned OP_W = 8;
    localparam int unsigned TM_W = 8;

    // Control-enable bit positions; bits 12..63 are unused and stay 0.
    localparam int unsigned ADDR_RP      = 0;
    localparam int unsigned WRITE_EN     = 1;
    localparam int unsigned TIMING_RESET = 2;
    localparam int unsigned PC_HOLD      = 3;
    localparam int unsigned PC_OPERAND   = 4;
    localparam int unsigned ALU_A_OPERAND = 5;
    localparam int unsigned ALU_OP_OR    = 6;
    localparam int unsigned DATA_OUT_RA  = 7;
    localparam int unsigned RA_ALU_OUT   = 8;
    localparam int unsigned RX_ALU_OUT   = 9;
    localparam int unsigned RY_ALU_OUT   = 10;
    localparam int unsigned RP_OPERAND   = 11;

    // Supported opcodes.
    localparam logic [OP_W-1:0] OP_NOP     = 8'hEA;
    localparam logic [OP_W-1:0] OP_LDA_IMM = 8'hA9;
    localparam logic [OP_W-1:0] OP_LDX_IMM = 8'hA2;
    localparam logic [OP_W-1:0] OP_LDY_IMM = 8'hA0;
    localparam logic [OP_W-1:0] OP_STA_ABS = 8'h8D;
    localparam logic [OP_W-1:0] OP_JMP_ABS = 8'h4C;

    // One-hot timing step positions.
    localparam int unsigned T0 = 0;
    localparam int unsigned T1 = 1;
    localparam int unsigned T2 = 2;
    localparam int unsigned T3 = 3;
    localparam int unsigned T4 = 4;

    typedef logic [EN_W-1:0] enables_t;

    // Single-bit enable mask for a given bit position.
    function automatic enables_t en_bit(input int unsigned idx);
        enables_t m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

    // True when exactly one timing bit is set.
    function automatic logic is_onehot(input logic [TM_W-1:0] t);
        return (t != '0) && ((t & (t - 8'd1)) == '0);
    endfunction

    // True for opcodes the core implements.
    function automatic logic is_supported(input logic [OP_W-1:0] op);
        logic s;
        s = 1'b0;
        case (op)
            OP_NOP, OP_LDA_IMM, OP_LDX_IMM,
            OP_LDY_IMM, OP_STA_ABS, OP_JMP_ABS: s = 1'b1;
            default: s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/decode_logic_if.sv
// Decoder bundle between the CPU sequencer (master) and decoder (slave):
// step/opcode go in, control enables and illegal flag come back.
interface decode_logic_if;
    import decode_logic_pkg::*;

    logic [TM_W-1:0] timing;
    logic [OP_W-1:0] opcode;
    enables_t        enables;
    logic            illegal;

    modport master (
        output timing,
        output opcode,
        input  enables,
        input  illegal
    );

    modport slave (
        input  timing,
        input  opcode,
        output enables,
        output illegal
    );

endinterface

// File: rtl/decode_logic.sv
// Opcode/timing-step decoder producing the 64-bit control enable vector,
// with a registered post-reset flag and a sticky illegal-opcode flag.
module decode_logic
    import decode_logic_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    decode_logic_if.slave  dec
);

    logic     first_q, first_d;
    logic     illegal_q, illegal_d;
    enables_t enables_c;
    enables_t step_en;
    logic     onehot;

    // Per-opcode step decode; steps past an opcode's last one end the instruction.
    always_comb begin
        step_en = en_bit(TIMING_RESET);
        onehot  = is_onehot(dec.timing);
        case (dec.opcode)
            OP_NOP: begin
                step_en = en_bit(TIMING_RESET);
            end
            OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM: begin
                if (dec.timing[T0]) begin
                    step_en = '0;
                end else if (dec.timing[T1]) begin
                    step_en = en_bit(ALU_A_OPERAND)
                            | en_bit(ALU_OP_OR)
                            | en_bit(TIMING_RESET);
                    if (dec.opcode == OP_LDA_IMM)
                        step_en = step_en | en_bit(RA_ALU_OUT);
                    else if (dec.opcode == OP_LDX_IMM)
                        step_en = step_en | en_bit(RX_ALU_OUT);
                    else
                        step_en = step_en | en_bit(RY_ALU_OUT);
                end
            end
            OP_STA_ABS: begin
                if (dec.timing[T0] || dec.timing[T1]) begin
                    step_en = '0;
                end else if (dec.timing[T2]) begin
                    step_en = en_bit(RP_OPERAND) | en_bit(PC_HOLD);
                end else if (dec.timing[T3]) begin
                    step_en = en_bit(ADDR_RP)
                            | en_bit(WRITE_EN)
                            | en_bit(DATA_OUT_RA)
                            | en_bit(PC_HOLD);
                end else if (dec.timing[T4]) begin
                    step_en = en_bit(TIMING_RESET);
                end
            end
            OP_JMP_ABS: begin
                if (dec.timing[T0] || dec.timing[T1]) begin
                    step_en = '0;
                end else if (dec.timing[T2]) begin
                    step_en = en_bit(PC_OPERAND) | en_bit(TIMING_RESET);
                end
            end
            default: begin
                step_en = en_bit(TIMING_RESET);
            end
        endcase
    end

    // Final enable selection: reset, then post-reset fetch, then sanity, then decode.
    always_comb begin
        enables_c = '0;
        if (reset) begin
            enables_c = '0;
        end else if (first_q) begin
            enables_c = en_bit(TIMING_RESET) | en_bit(PC_HOLD);
        end else if (!onehot) begin
            enables_c = en_bit(TIMING_RESET);
        end else begin
            enables_c = step_en;
        end
    end

    // Next-state for the flags; decode is inactive during the post-reset cycle.
    always_comb begin
        first_d   = 1'b0;
        illegal_d = illegal_q;
        if (!first_q && dec.timing[T0] && !is_supported(dec.opcode))
            illegal_d = 1'b1;
    end

    // Flag registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            first_q   <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            first_q   <= first_d;
            illegal_q <= illegal_d;
        end
    end

    assign dec.enables = enables_c;
    assign dec.illegal = illegal_q;

endmodule

// File: tb/tb_decode_logic.sv
// Directed-vector bench for decode_logic: stimulus pushes expected
// enables/illegal into a scoreboard queue, a negedge monitor checks them.
module tb_decode_logic;
    import decode_logic_pkg::*;

    typedef struct {
        string       name;
        logic [63:0] en;
        logic        ill;
    } exp_t;

    logic clock;
    logic reset;
    exp_t sb[$];
    int   n_vec;
    int   n_bad;
    logic done;

    decode_logic_if dif();

    decode_logic u_dut (
        .clock (clock),
        .reset (reset),
        .dec   (dif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic vec(input logic r, input logic [7:0] t,
                       input logic [7:0] op, input logic [63:0] e,
                       input logic il, input string nm);
        exp_t x;
        @(posedge clock);
        #1;
        reset      = r;
        dif.timing = t;
        dif.opcode = op;
        x.name = nm;
        x.en   = e;
        x.ill  = il;
        sb.push_back(x);
    endtask

    // Monitor: compare each queued expectation mid-cycle.
    always @(negedge clock) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            n_vec++;
            if (dif.enables !== x.en || dif.illegal !== x.ill) begin
                n_bad++;
                $display("FAIL %s: got en=%h ill=%b, want en=%h ill=%b",
                         x.name, dif.enables, dif.illegal, x.en, x.ill);
            end
        end
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        done  = 1'b0;
        reset      = 1'b1;
        dif.timing = 8'h01;
        dif.opcode = 8'hEA;

        vec(1, 8'h01, 8'hEA, 64'h0000, 0, "reset");
        vec(0, 8'h04, 8'h4C, 64'h000C, 0, "first_cycle");
        vec(0, 8'h01, 8'hEA, 64'h0004, 0, "nop_t0");

        vec(0, 8'h01, 8'hA9, 64'h0000, 0, "lda_t0");
        vec(0, 8'h02, 8'hA9, 64'h0164, 0, "lda_t1");
        vec(0, 8'h01, 8'hA2, 64'h0000, 0, "ldx_t0");
        vec(0, 8'h02, 8'hA2, 64'h0264, 0, "ldx_t1");
        vec(0, 8'h01, 8'hA0, 64'h0000, 0, "ldy_t0");
        vec(0, 8'h02, 8'hA0, 64'h0464, 0, "ldy_t1");

        vec(0, 8'h01, 8'h8D, 64'h0000, 0, "sta_t0");
        vec(0, 8'h02, 8'h8D, 64'h0000, 0, "sta_t1");
        vec(0, 8'h04, 8'h8D, 64'h0808, 0, "sta_t2");
        vec(0, 8'h08, 8'h8D, 64'h008B, 0, "sta_t3");
        vec(0, 8'h10, 8'h8D, 64'h0004, 0, "sta_t4");
        vec(0, 8'h20, 8'h8D, 64'h0004, 0, "sta_past");

        vec(0, 8'h01, 8'h4C, 64'h0000, 0, "jmp_t0");
        vec(0, 8'h02, 8'h4C, 64'h0000, 0, "jmp_t1");
        vec(0, 8'h04, 8'h4C, 64'h0014, 0, "jmp_t2");
        vec(0, 8'h08, 8'h4C, 64'h0004, 0, "jmp_past");
        vec(0, 8'h02, 8'hEA, 64'h0004, 0, "nop_past");

        vec(0, 8'h08, 8'hA9, 64'h0004, 0, "def_lda_t3");
        vec(0, 8'h03, 8'hA9, 64'h0004, 0, "def_multi");
        vec(0, 8'h00, 8'hA9, 64'h0004, 0, "def_zero");
        vec(0, 8'h06, 8'h8D, 64'h0004, 0, "def_sta_multi");

        vec(0, 8'h02, 8'hFF, 64'h0004, 0, "ill_t1_noset");
        vec(0, 8'h01, 8'hEA, 64'h0004, 0, "ill_still_low");
        vec(0, 8'h01, 8'hFF, 64'h0004, 0, "ill_ff_t0");
        vec(0, 8'h01, 8'hEA, 64'h0004, 1, "ill_set");
        vec(0, 8'h02, 8'hA9, 64'h0164, 1, "ill_hold_lda");
        vec(0, 8'h04, 8'h8D, 64'h0808, 1, "ill_hold_sta");

        vec(1, 8'h02, 8'hA9, 64'h0000, 1, "rst2_gate");
        vec(1, 8'h01, 8'hEA, 64'h0000, 0, "rst2_clear");
        vec(0, 8'h01, 8'h00, 64'h000C, 0, "first2");
        vec(0, 8'h01, 8'h00, 64'h0004, 0, "op00_t0");
        vec(0, 8'h01, 8'hEA, 64'h0004, 1, "op00_ill");

        for (int i = 0; i < 20 && sb.size() > 0; i++)
            @(posedge clock);
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
